// File: rtl/mem_bus_pkg.sv
// Shared constants and encodings for the core/host memory bus arbiter.
// Imported by the arbiter and its starvation counter.
package mem_bus_pkg;

  localparam int AW         = 9;
  localparam int DW         = 8;
  localparam int MAX_BURST  = 4;
  localparam int STARVE_MAX = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_HLOCK = 1'b1;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_HOST = 2'b01,
    RD_CORE = 2'b10
  } rd_owner_e;

  // Grants are exclusive, so at most one of the two read flags is ever set.
  function automatic rd_owner_e rdOwnerOf(input logic coreRead, input logic hostRead);
    if (coreRead) return RD_CORE;
    if (hostRead) return RD_HOST;
    return RD_NONE;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_starve_counter.sv
// Saturating host-wait counter with clear.
// Flags when the host has waited the full starvation limit.
module starve_counter
  import mem_bus_pkg::*;
#(
  parameter int LIMIT = STARVE_MAX
) (
  input  logic r_clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && (count_q != LIMIT_C))
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign at_limit_o = (count_q == LIMIT_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU core and the host loader,
// with core priority, a host starvation guard and short host-locked bursts.
module mem_bus_arbiter #(
  parameter int AW         = mem_bus_pkg::AW,
  parameter int DW         = mem_bus_pkg::DW,
  parameter int MAX_BURST  = mem_bus_pkg::MAX_BURST,
  parameter int STARVE_MAX = mem_bus_pkg::STARVE_MAX
) (
  input  logic          r_clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_ab,
  input  logic [DW-1:0] c_do,
  output logic          c_gnt,
  output logic [DW-1:0] c_di,
  output logic          c_rvalid,
  input  logic          h_req,
  input  logic          h_we,
  input  logic          h_lock,
  input  logic [AW-1:0] h_ab,
  input  logic [DW-1:0] h_wd,
  output logic          h_gnt,
  output logic [DW-1:0] h_rd,
  output logic          h_rvalid,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_ab,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd
);

  import mem_bus_pkg::*;

  localparam int BW = $clog2(MAX_BURST + 1);
  // burst_q counts beats already completed, so the beat seen at MAX_BURST-1 is the last one.
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  logic [0:0]    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          postBurst_q, postBurst_d;
  rd_owner_e     rdOwner_q;
  logic          hostStarved;

  starve_counter #(
    .LIMIT(STARVE_MAX)
  ) u_starve (
    .r_clk     (r_clk),
    .reset     (reset),
    .inc_i     (h_req & ~h_gnt & (state_q == ST_IDLE)),
    .clr_i     (h_gnt | ~h_req),
    .at_limit_o(hostStarved)
  );

  // Grants are held off while reset is high so nothing reaches the memory mid-reset.
  always_comb begin
    h_gnt = 1'b0;
    c_gnt = 1'b0;
    if (!reset) begin
      if (state_q == ST_HLOCK) begin
        h_gnt = h_req;
      end else begin
        h_gnt = h_req & (~c_req | (hostStarved & ~postBurst_q));
        c_gnt = c_req & ~h_gnt;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    postBurst_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (h_gnt && h_lock && (MAX_BURST > 1)) begin
        state_d = ST_HLOCK;
        burst_d = BW'(1);
      end
    end else begin
      if (h_gnt)
        burst_d = burst_q + BW'(1);
      if (!h_req || !h_lock || (h_gnt && (burst_q == LAST_BEAT))) begin
        state_d     = ST_IDLE;
        burst_d     = '0;
        postBurst_d = 1'b1;
      end
    end
  end

  always_ff @(posedge r_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_q     <= '0;
      postBurst_q <= 1'b0;
      rdOwner_q   <= RD_NONE;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      postBurst_q <= postBurst_d;
      rdOwner_q   <= rdOwnerOf(c_gnt & ~c_we, h_gnt & ~h_we);
    end
  end

  always_comb begin
    m_we = 1'b0;
    m_ab = '0;
    m_wd = '0;
    if (h_gnt) begin
      m_we = h_we;
      m_ab = h_ab;
      m_wd = h_wd;
    end else if (c_gnt) begin
      m_we = c_we;
      m_ab = c_ab;
      m_wd = c_do;
    end
  end

  assign m_en     = c_gnt | h_gnt;
  assign c_rvalid = (rdOwner_q == RD_CORE);
  assign h_rvalid = (rdOwner_q == RD_HOST);
  assign c_di     = m_rd;
  assign h_rd     = m_rd;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the arbiter and memory.
module tb_mem_bus_arbiter;

  localparam int MAX_BURST  = 4;
  localparam int STARVE_MAX = 8;

  logic       r_clk = 1'b0;
  logic       reset = 1'b0;
  logic       c_req = 1'b0, c_we = 1'b0;
  logic [8:0] c_ab = '0;
  logic [7:0] c_do = '0;
  logic       c_gnt, c_rvalid;
  logic [7:0] c_di;
  logic       h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
  logic [8:0] h_ab = '0;
  logic [7:0] h_wd = '0;
  logic       h_gnt, h_rvalid;
  logic [7:0] h_rd;
  logic       m_en, m_we;
  logic [8:0] m_ab;
  logic [7:0] m_wd;
  logic [7:0] m_rd;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram    [512];
  logic [7:0] refMem [512];

  // Model state: whole-burst view of the host lock and a plain wait counter.
  bit         mInBurst, mAfterBurst, mPendC, mPendH;
  int         mBeats, mWait;
  logic [7:0] mPendData;

  always #5 r_clk = ~r_clk;

  mem_bus_arbiter dut (
    .r_clk(r_clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_ab(c_ab), .c_do(c_do),
    .c_gnt(c_gnt), .c_di(c_di), .c_rvalid(c_rvalid),
    .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_ab(h_ab), .h_wd(h_wd),
    .h_gnt(h_gnt), .h_rd(h_rd), .h_rvalid(h_rvalid),
    .m_en(m_en), .m_we(m_we), .m_ab(m_ab), .m_wd(m_wd), .m_rd(m_rd)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs just after a posedge and returns at the following negedge.
  task automatic applyStimulus(input logic cr, input logic cw, input logic [8:0] ca,
                               input logic [7:0] cd, input logic hr, input logic hw,
                               input logic hl, input logic [8:0] ha, input logic [7:0] hd);
    @(posedge r_clk);
    #1;
    c_req = cr; c_we = cw; c_ab = ca; c_do = cd;
    h_req = hr; h_we = hw; h_lock = hl; h_ab = ha; h_wd = hd;
    @(negedge r_clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
  endtask

  // Synchronous 512x8 memory behind the arbiter.
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[9'h105] = 8'h5A;
    forever begin
      @(posedge r_clk);
      if (m_en) begin
        if (m_we) ram[m_ab] = m_wd;
        else      m_rd <= ram[m_ab];
      end
    end
  end

  // Reference model and per-cycle compare.
  initial begin : model
    bit         eh, ec, eWe, starving, endBurst, wasInBurst;
    logic [8:0] eAb;
    logic [7:0] eWd;
    for (int i = 0; i < 512; i++) refMem[i] = 8'(i) ^ 8'hA5;
    refMem[9'h105] = 8'h5A;
    mInBurst = 0; mAfterBurst = 0; mPendC = 0; mPendH = 0; mBeats = 0; mWait = 0;
    forever begin
      @(negedge r_clk);
      if (reset) begin
        checkOutput("rst_c_gnt", 32'(c_gnt), 32'd0);
        checkOutput("rst_h_gnt", 32'(h_gnt), 32'd0);
        checkOutput("rst_m_en", 32'(m_en), 32'd0);
        checkOutput("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        checkOutput("rst_h_rvalid", 32'(h_rvalid), 32'd0);
        mInBurst = 0; mAfterBurst = 0; mPendC = 0; mPendH = 0; mBeats = 0; mWait = 0;
      end else begin
        checkOutput("c_rvalid", 32'(c_rvalid), 32'(mPendC));
        checkOutput("h_rvalid", 32'(h_rvalid), 32'(mPendH));
        if (mPendC) checkOutput("c_di", 32'(c_di), 32'(mPendData));
        if (mPendH) checkOutput("h_rd", 32'(h_rd), 32'(mPendData));

        if (mInBurst) begin
          eh = h_req;
          ec = 1'b0;
        end else begin
          starving = (mWait >= STARVE_MAX) && !mAfterBurst;
          eh = h_req && (!c_req || starving);
          ec = c_req && !eh;
        end
        eWe = 1'b0; eAb = '0; eWd = '0;
        if (eh)      begin eWe = h_we; eAb = h_ab; eWd = h_wd; end
        else if (ec) begin eWe = c_we; eAb = c_ab; eWd = c_do; end

        checkOutput("c_gnt", 32'(c_gnt), 32'(ec));
        checkOutput("h_gnt", 32'(h_gnt), 32'(eh));
        checkOutput("m_en", 32'(m_en), 32'(eh || ec));
        checkOutput("m_we", 32'(m_we), 32'(eWe));
        checkOutput("m_ab", 32'(m_ab), 32'(eAb));
        checkOutput("m_wd", 32'(m_wd), 32'(eWd));

        if (eh || ec) begin
          if (eWe) refMem[eAb] = eWd;
          else     mPendData = refMem[eAb];
        end
        mPendC = ec && !c_we;
        mPendH = eh && !h_we;

        wasInBurst = mInBurst;
        if (!h_req || eh)                           mWait = 0;
        else if (!wasInBurst && mWait < STARVE_MAX) mWait++;

        endBurst = 0;
        if (mInBurst) begin
          if (eh) mBeats++;
          if (!h_req || !h_lock || mBeats == MAX_BURST) begin
            mInBurst = 0; mBeats = 0; endBurst = 1;
          end
        end else if (eh && h_lock && MAX_BURST > 1) begin
          mInBurst = 1; mBeats = 1;
        end
        mAfterBurst = endBurst;
      end
    end
  end

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(posedge r_clk);
    #1 reset = 1'b0;

    // Core-only read of a preloaded location.
    applyStimulus(1'b1, 1'b0, 9'h105, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    checkOutput("t1_c_gnt", 32'(c_gnt), 32'd1);
    idleCycle();
    checkOutput("t1_c_rvalid", 32'(c_rvalid), 32'd1);
    checkOutput("t1_c_di", 32'(c_di), 32'h5A);

    // Both requesting: core wins eight times, host wins the ninth, core again after.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0, 9'h100 + 9'(i), 8'h00, 1'b1, 1'b0, 1'b0, 9'h0E0, 8'h00);
      checkOutput($sformatf("t2_c_gnt_%0d", i), 32'(c_gnt), 32'(i < 9));
      checkOutput($sformatf("t2_h_gnt_%0d", i), 32'(h_gnt), 32'(i == 9));
    end
    applyStimulus(1'b1, 1'b0, 9'h100, 8'h00, 1'b1, 1'b0, 1'b0, 9'h0E0, 8'h00);
    checkOutput("t2_c_gnt_after", 32'(c_gnt), 32'd1);
    checkOutput("t2_h_rd", 32'(h_rd), 32'h45);
    idleCycle();

    // Locked host burst of six requests: four beats, then core gets the bus.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(i > 1, 1'b0, 9'h100, 8'h00, 1'b1, 1'b1, 1'b1, 9'h040 + 9'(i), 8'hC0 + 8'(i));
      checkOutput($sformatf("t3_h_gnt_%0d", i), 32'(h_gnt), 32'(i <= 4));
      checkOutput($sformatf("t3_c_gnt_%0d", i), 32'(c_gnt), 32'(i >= 5));
    end
    idleCycle();

    // Host write followed immediately by a core read of the same address.
    applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b1, 1'b0, 9'h033, 8'h77);
    applyStimulus(1'b1, 1'b0, 9'h033, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    idleCycle();
    checkOutput("t4_c_rvalid", 32'(c_rvalid), 32'd1);
    checkOutput("t4_c_di", 32'(c_di), 32'h77);

    // Alternating host and core reads keep their own tags.
    applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 1'b0, 9'h010, 8'h00);
    applyStimulus(1'b1, 1'b0, 9'h011, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    checkOutput("t5_h_rvalid", 32'(h_rvalid), 32'd1);
    checkOutput("t5_c_rvalid0", 32'(c_rvalid), 32'd0);
    checkOutput("t5_h_rd", 32'(h_rd), 32'hB5);
    applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 1'b0, 9'h012, 8'h00);
    checkOutput("t5_c_rvalid", 32'(c_rvalid), 32'd1);
    checkOutput("t5_h_rvalid0", 32'(h_rvalid), 32'd0);
    checkOutput("t5_c_di", 32'(c_di), 32'hB4);
    idleCycle();
    checkOutput("t5_h_rd2", 32'(h_rd), 32'hB7);

    // Reset pulse in the middle of a locked host read burst.
    applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 1'b1, 9'h020, 8'h00);
    applyStimulus(1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 1'b1, 9'h021, 8'h00);
    checkOutput("t6_h_gnt_locked", 32'(h_gnt), 32'd1);
    @(posedge r_clk);
    #1 reset = 1'b1;
    @(negedge r_clk);
    checkOutput("t6_h_rvalid", 32'(h_rvalid), 32'd0);
    checkOutput("t6_m_en", 32'(m_en), 32'd0);
    @(posedge r_clk);
    #1 reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_ab = 9'h100;
    @(negedge r_clk);
    checkOutput("t6_c_gnt_idle", 32'(c_gnt), 32'd1);
    checkOutput("t6_h_gnt_idle", 32'(h_gnt), 32'd0);

    // Randomized traffic with sticky host request/lock so bursts and starvation occur.
    for (int n = 0; n < 3000; n++) begin
      @(posedge r_clk);
      #1;
      reset  = ($urandom_range(0, 199) == 0);
      c_req  = ($urandom_range(0, 3) != 0);
      c_we   = ($urandom_range(0, 2) == 0);
      c_ab   = {1'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 15))};
      c_do   = 8'($urandom);
      if ($urandom_range(0, 7) == 0) h_req = ~h_req;
      if ($urandom_range(0, 5) == 0) h_lock = ~h_lock;
      h_we   = ($urandom_range(0, 2) == 0);
      h_ab   = {1'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 15))};
      h_wd   = 8'($urandom);
    end
    @(posedge r_clk);
    #1 reset = 1'b0;
    idleCycle();
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
